// File: rtl/gpu_pkg.sv
// gpu_pkg: shared core FSM encoding and fetcher/LSU handshake codes.
// Revision: 1.0
`default_nettype none

package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;
  localparam logic [1:0] LSU_REQUESTING  = 2'b01;
  localparam logic [1:0] LSU_WAITING     = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pc_min_select.sv
// pc_min_select: unsigned minimum over valid candidate PCs plus the mask of all ties.
// Revision: 1.0
`default_nettype none

module pc_min_select #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] cand_pc,
  input  logic [THREADS_PER_BLOCK-1:0]         valid,
  output logic [PC_BITS-1:0]                   min_pc,
  output logic [THREADS_PER_BLOCK-1:0]         eq_mask,
  output logic                                 any_valid
);

  always_comb begin
    min_pc    = '1;
    any_valid = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (valid[i] && (!any_valid || (cand_pc[i*PC_BITS +: PC_BITS] < min_pc))) begin
        min_pc = cand_pc[i*PC_BITS +: PC_BITS];
      end
      if (valid[i]) begin
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    eq_mask = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      eq_mask[i] = valid[i] && (cand_pc[i*PC_BITS +: PC_BITS] == min_pc);
    end
  end

endmodule

`default_nettype wire

// File: rtl/divergent_scheduler.sv
// divergent_scheduler: per-core block sequencer issuing the minimum live PC with an
// active-thread mask so divergent paths serialise and reconverge. Revision: 1.0
`default_nettype none

module divergent_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
  input  logic                                 decoded_ret,
  input  logic [2:0]                           fetcher_state,
  input  logic [THREADS_PER_BLOCK*2-1:0]       lsu_state,
  input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc,
  output logic [PC_BITS-1:0]                   current_pc,
  output logic [THREADS_PER_BLOCK-1:0]         thread_mask,
  output logic [2:0]                           core_state,
  output logic                                 done
);

  core_state_t                         r_state;
  logic [PC_BITS-1:0]                  r_thread_pc [THREADS_PER_BLOCK];
  logic [THREADS_PER_BLOCK-1:0]        r_live;

  logic [THREADS_PER_BLOCK*PC_BITS-1:0] w_cand;
  logic [THREADS_PER_BLOCK-1:0]         w_survivors;
  logic [THREADS_PER_BLOCK-1:0]         w_launch_live;
  logic [THREADS_PER_BLOCK-1:0]         w_lsu_busy;
  logic [THREADS_PER_BLOCK-1:0]         w_eq_mask;
  logic [PC_BITS-1:0]                   w_min_pc;
  logic                                 w_any_survivor;

  generate
    for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_thread
      assign w_cand[i*PC_BITS +: PC_BITS] = thread_mask[i] ? next_pc[i*PC_BITS +: PC_BITS]
                                                           : r_thread_pc[i];
      assign w_launch_live[i] = (32'(thread_count) > i);
      assign w_lsu_busy[i]    = thread_mask[i] &&
                                ((lsu_state[i*2 +: 2] == LSU_REQUESTING) ||
                                 (lsu_state[i*2 +: 2] == LSU_WAITING));
    end
  endgenerate

  // Threads executing RET this cycle drop out of the candidate set.
  assign w_survivors = r_live & ~(decoded_ret ? thread_mask : '0);

  pc_min_select #(
    .THREADS_PER_BLOCK (THREADS_PER_BLOCK),
    .PC_BITS           (PC_BITS)
  ) u_pc_min_select (
    .cand_pc   (w_cand),
    .valid     (w_survivors),
    .min_pc    (w_min_pc),
    .eq_mask   (w_eq_mask),
    .any_valid (w_any_survivor)
  );

  assign core_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CORE_IDLE;
      current_pc  <= '0;
      thread_mask <= '0;
      done        <= 1'b0;
      r_live      <= '0;
      for (int i = 0; i < THREADS_PER_BLOCK; i++) r_thread_pc[i] <= '0;
    end else begin
      case (r_state)
        CORE_IDLE: begin
          if (start) begin
            if (thread_count == '0) begin
              done    <= 1'b1;
              r_state <= CORE_DONE;
            end else begin
              for (int i = 0; i < THREADS_PER_BLOCK; i++) r_thread_pc[i] <= '0;
              r_live      <= w_launch_live;
              current_pc  <= '0;
              thread_mask <= w_launch_live;
              r_state     <= CORE_FETCH;
            end
          end
        end
        CORE_FETCH:   if (fetcher_state == FETCHER_FETCHED) r_state <= CORE_DECODE;
        CORE_DECODE:  r_state <= CORE_REQUEST;
        CORE_REQUEST: r_state <= CORE_WAIT;
        CORE_WAIT:    if (w_lsu_busy == '0) r_state <= CORE_EXECUTE;
        CORE_EXECUTE: r_state <= CORE_UPDATE;
        CORE_UPDATE: begin
          for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_mask[i]) begin
              if (decoded_ret) r_live[i] <= 1'b0;
              else             r_thread_pc[i] <= next_pc[i*PC_BITS +: PC_BITS];
            end
          end
          if (!w_any_survivor) begin
            done        <= 1'b1;
            thread_mask <= '0;
            r_state     <= CORE_DONE;
          end else begin
            current_pc  <= w_min_pc;
            thread_mask <= w_eq_mask;
            r_state     <= CORE_FETCH;
          end
        end
        default: r_state <= CORE_DONE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divergent_scheduler.sv
// tb_divergent_scheduler: directed checks of issue order, divergence, LSU gating and reset.
// Revision: 1.0
`default_nettype none

module tb_divergent_scheduler;

  localparam int c_T  = 4;
  localparam int c_PB = 8;

  localparam logic [2:0] c_IDLE = 3'b000, c_FETCH = 3'b001, c_WAIT = 3'b100;
  localparam logic [2:0] c_EXEC = 3'b101, c_UPDATE = 3'b110, c_DONE = 3'b111;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        thread_count;
  logic              decoded_ret;
  logic [2:0]        fetcher_state;
  logic [c_T*2-1:0]  lsu_state;
  logic [c_T*c_PB-1:0] next_pc;
  logic [c_PB-1:0]   current_pc;
  logic [c_T-1:0]    thread_mask;
  logic [2:0]        core_state;
  logic              done;

  int checks   = 0;
  int failures = 0;

  divergent_scheduler #(.THREADS_PER_BLOCK(c_T), .PC_BITS(c_PB)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .thread_count  (thread_count),
    .decoded_ret   (decoded_ret),
    .fetcher_state (fetcher_state),
    .lsu_state     (lsu_state),
    .next_pc       (next_pc),
    .current_pc    (current_pc),
    .thread_mask   (thread_mask),
    .core_state    (core_state),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_issue(input string tag, input logic [7:0] pc, input logic [3:0] mask);
    check({tag, "_state"}, 32'(core_state), 32'(c_FETCH));
    check({tag, "_pc"}, 32'(current_pc), 32'(pc));
    check({tag, "_mask"}, 32'(thread_mask), 32'(mask));
  endtask

  // next_pc given as {t3,t2,t1,t0}
  task automatic run_instr(input logic [31:0] npc, input logic ret);
    next_pc     = npc;
    decoded_ret = ret;
    step(6);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic launch(input logic [2:0] cnt);
    start        = 1'b1;
    thread_count = cnt;
    step(1);
    start        = 1'b0;
  endtask

  // PC0 -> PC1 -> PC2 -> diverge to PC5 with mask 0101
  task automatic reach_pc5();
    launch(3'd4);
    run_instr({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0);
    run_instr({8'd2, 8'd2, 8'd2, 8'd2}, 1'b0);
    run_instr({8'd9, 8'd5, 8'd9, 8'd5}, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; thread_count = 3'd0; decoded_ret = 1'b0;
    fetcher_state = 3'b010; lsu_state = '0; next_pc = '0;
    step(2);
    check("rst_state", 32'(core_state), 32'(c_IDLE));
    check("rst_pc", 32'(current_pc), 32'd0);
    check("rst_mask", 32'(thread_mask), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Convergent 4-instruction program, RET at PC 3, 24 cycles start-to-done
    launch(3'd4);
    check_issue("conv0", 8'd0, 4'b1111);
    run_instr({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0);
    check_issue("conv1", 8'd1, 4'b1111);
    run_instr({8'd2, 8'd2, 8'd2, 8'd2}, 1'b0);
    check_issue("conv2", 8'd2, 4'b1111);
    run_instr({8'd3, 8'd3, 8'd3, 8'd3}, 1'b0);
    check_issue("conv3", 8'd3, 4'b1111);
    decoded_ret = 1'b1;
    step(5);
    check("conv_upd_state", 32'(core_state), 32'(c_UPDATE));
    check("conv_upd_done", 32'(done), 32'd0);
    step(1);
    check("conv_done_state", 32'(core_state), 32'(c_DONE));
    check("conv_done", 32'(done), 32'd1);
    check("conv_done_mask", 32'(thread_mask), 32'd0);
    check("conv_done_pc", 32'(current_pc), 32'd3);
    decoded_ret = 1'b0;
    launch(3'd4);
    check("done_ignores_start", 32'(core_state), 32'(c_DONE));
    check("done_sticky", 32'(done), 32'd1);
    do_reset();

    // Divergence at PC 2, reconvergence at PC 9
    reach_pc5();
    check_issue("div5", 8'd5, 4'b0101);
    run_instr({8'd9, 8'd9, 8'd9, 8'd9}, 1'b0);
    check_issue("reconv9", 8'd9, 4'b1111);
    run_instr({8'd0, 8'd0, 8'd0, 8'd0}, 1'b1);
    check("reconv_done", 32'(done), 32'd1);
    do_reset();

    // Partial RET with LSU gating
    reach_pc5();
    check_issue("pret5", 8'd5, 4'b0101);
    lsu_state   = 8'b00_01_10_00;   // t2 REQUESTING (masked), t1 WAITING (unmasked)
    decoded_ret = 1'b1;
    step(3);
    check("lsu_wait_enter", 32'(core_state), 32'(c_WAIT));
    step(3);
    check("lsu_wait_held", 32'(core_state), 32'(c_WAIT));
    lsu_state = 8'b00_00_10_00;     // only unmasked t1 busy
    step(1);
    check("lsu_wait_exit", 32'(core_state), 32'(c_EXEC));
    lsu_state = '0;
    step(2);
    check_issue("pret9", 8'd9, 4'b1010);
    lsu_state = 8'b00_00_10_00;     // t1 now masked and WAITING
    step(5);
    check("lsu_masked_wait", 32'(core_state), 32'(c_WAIT));
    lsu_state = '0;
    step(1);
    check("lsu_masked_exit", 32'(core_state), 32'(c_EXEC));
    step(2);
    check("pret_done_state", 32'(core_state), 32'(c_DONE));
    check("pret_done", 32'(done), 32'd1);
    check("pret_done_mask", 32'(thread_mask), 32'd0);
    check("pret_done_pc", 32'(current_pc), 32'd9);
    decoded_ret = 1'b0;
    do_reset();

    // Partial thread count; non-live thread 3 candidate must be ignored
    launch(3'd3);
    check_issue("cnt3", 8'd0, 4'b0111);
    run_instr({8'd0, 8'd1, 8'd1, 8'd1}, 1'b0);
    check_issue("cnt3_next", 8'd1, 4'b0111);
    do_reset();
    launch(3'd7);
    check_issue("cnt7_sat", 8'd0, 4'b1111);
    do_reset();
    launch(3'd0);
    check("cnt0_state", 32'(core_state), 32'(c_DONE));
    check("cnt0_done", 32'(done), 32'd1);
    check("cnt0_mask", 32'(thread_mask), 32'd0);
    do_reset();

    // Reset in WAIT with divergent state
    reach_pc5();
    step(3);
    check("mid_wait", 32'(core_state), 32'(c_WAIT));
    do_reset();
    check("mid_rst_state", 32'(core_state), 32'(c_IDLE));
    check("mid_rst_pc", 32'(current_pc), 32'd0);
    check("mid_rst_mask", 32'(thread_mask), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    launch(3'd4);
    check_issue("fresh0", 8'd0, 4'b1111);
    run_instr({8'd3, 8'd1, 8'd3, 8'd1}, 1'b0);
    check_issue("fresh1", 8'd1, 4'b0101);
    run_instr({8'd0, 8'd3, 8'd0, 8'd3}, 1'b0);
    check_issue("fresh3", 8'd3, 4'b1111);

    // Fetch stall holds FETCH
    fetcher_state = 3'b001;
    step(4);
    check("fetch_stall", 32'(core_state), 32'(c_FETCH));
    fetcher_state = 3'b010;
    step(1);
    check("fetch_go", 32'(core_state), 32'(3'b010));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/divergent_scheduler.md
# divergent_scheduler

Per-core control-flow sequencer that runs one block through FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE and supports branch divergence. Each thread keeps its own PC. The scheduler always issues the minimum PC among live threads, with an active-thread mask, so divergent paths serialise and reconverge automatically. It sits in the compute core between the fetcher, decoder, LSUs and per-thread PC units, and drives the shared `current_pc` and `thread_mask` used to gate register/LSU/PC writes.

## Interface
- `THREADS_PER_BLOCK`, 4, threads per block (≥1)
- `PC_BITS`, 8, program counter width
- `clk` in 1: clock; all logic on posedge
- `reset` in 1: synchronous, active-high
- `start` in 1: launch block; sampled only in IDLE
- `thread_count` in $clog2(THREADS_PER_BLOCK)+1: live threads in this block, sampled at launch
- `decoded_ret` in 1: current instruction is RET
- `fetcher_state` in 3: fetcher FSM state; 3'b010 = FETCHED
- `lsu_state` in [THREADS_PER_BLOCK] × 2: per-thread LSU state; 2'b01 REQUESTING, 2'b10 WAITING
- `next_pc` in [THREADS_PER_BLOCK] × PC_BITS: per-thread next PC from PC units
- `current_pc` out PC_BITS: PC being issued
- `thread_mask` out THREADS_PER_BLOCK: bit i = thread i executes current instruction
- `core_state` out 3: FSM state
- `done` out 1: block finished, sticky until reset

## Operation
- States and encoding: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Internal state: `thread_pc[i]` (PC_BITS) and `live[i]` (1) per thread.
- IDLE → on `start`:
  - `thread_count`==0: `done`<=1, go to DONE.
  - Otherwise: `thread_pc[*]`<=0; `live[i]`<=(i<thread_count), with counts above THREADS_PER_BLOCK saturating to all live; `current_pc`<=0; `thread_mask`<=`live`; go to FETCH.
- FETCH → DECODE when `fetcher_state`==3'b010; otherwise hold.
- DECODE → REQUEST → WAIT: one cycle each, unconditional.
- WAIT → EXECUTE when no thread i with `thread_mask[i]`=1 has `lsu_state[i]` ∈ {01,10}. Unmasked threads' LSU state is ignored.
- EXECUTE → UPDATE: one cycle.
- UPDATE, for masked threads:
  - If `decoded_ret`: `live[i]`<=0.
  - Else: `thread_pc[i]`<=`next_pc[i]`.
- UPDATE, candidate set: candidate PC = `next_pc[i]` if masked, else `thread_pc[i]`. Survivors = live threads not retiring this cycle.
  - No survivors: `done`<=1, `thread_mask`<=0, go to DONE; `current_pc` holds.
  - Otherwise: `current_pc`<=min candidate PC over survivors (unsigned); `thread_mask`<=survivors whose candidate equals that min (ties all included); go to FETCH.
- DONE: hold all outputs; `start` ignored; exit only via `reset`.
- `start` outside IDLE is ignored. Inputs are not latched except `thread_count` at launch.

## Timing
- Reset values: `current_pc`=0, `thread_mask`=0, `core_state`=IDLE, `done`=0, `thread_pc`=0, `live`=0.
- `reset` mid-operation: the next posedge restores all reset values. No partial retirement survives.
- All outputs are registered. `current_pc`/`thread_mask` change only on the IDLE→FETCH and UPDATE→FETCH edges, so they are stable from FETCH through UPDATE.
- Minimum instruction latency is 6 cycles (FETCHED present on first FETCH cycle, no LSU activity); each extra FETCH/WAIT cycle adds one.
- `done` rises on the same edge `core_state` becomes DONE.
- Min-PC selection is combinational within UPDATE. No extra pipeline stage.

## Structure
- Shared package `gpu_pkg`:
  - `core_state_t` enum (8 codes above).
  - `FETCHER_FETCHED`=3'b010.
  - `LSU_REQUESTING`=2'b01, `LSU_WAITING`=2'b10.
- One sub-module, `pc_min_select`: parametrised by THREADS_PER_BLOCK and PC_BITS. Takes candidate PCs plus a valid mask; returns min PC, equality mask and `any_valid`. Purely combinational, tree or linear reduction.

## Test plan
- Convergent loop: thread_count=4, all next_pc=PC+1 for 3 instructions, RET at PC 3 → current_pc 0,1,2,3; thread_mask=4'b1111 throughout; done after 4th UPDATE; 24 cycles start-to-done with immediate FETCHED.
- Divergence: at PC 2, next_pc={t0:5,t1:9,t2:5,t3:9} → issue PC 5 with mask 4'b0101. Masked threads then step to 9 → PC 9, mask 4'b1111 (reconverged).
- Partial RET: at PC 5, mask 0101 executes RET → next issue PC 9, mask 1010. RET there → done=1, mask=0.
- thread_count=3, THREADS_PER_BLOCK=4 → initial mask 4'b0111. thread_count=0 → DONE with done=1 one cycle after start.
- LSU gating: mask 0101; lsu_state[1]=WAITING held → WAIT exits immediately. lsu_state[2]=REQUESTING for 3 cycles → WAIT held exactly 3 extra cycles.
- Reset in WAIT with divergent state → next cycle IDLE, all outputs 0. A fresh start then runs from PC 0 with the full mask.
